usb_bit_timing_ctrl: RTL and testbench

// - Sequences the RX bit-timing datapath: owns the sysclk/N phase counter, emits one
//   mid-bit sample strobe per USB bit, and re-phases on every line transition (DPLL-lite).
// - Sits between the RX edge detector and the NRZI decoder / shift register.
// - Reports lock status and a bit-stuff timeout (no edge for too long).

---
 rtl/usb_bit_timing_ctrl.sv | 171 +++++++++++++++++
 tb/tb_usb_bit_timing_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_bit_timing_ctrl.sv
// rtl/usb_bit_timing_ctrl.sv - RX bit-timing controller: phase counter, mid-bit strobe, edge resync, lock and idle timeout.
// Optional slip statistics counter enabled by defining TIMING_STATS_EN.
module usb_bit_timing_ctrl #(
  parameter int CNT_BITS      = 4,
  parameter int LOCK_EDGES    = 3,
  parameter int MAX_IDLE_BITS = 7
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic                enable,
  input  logic [CNT_BITS-1:0] div_val,
  input  logic                line_edge,
  output logic                sample_en,
  output logic [CNT_BITS-1:0] phase_cnt,
  output logic                locked,
  output logic                busy,
  output logic                timeout,
  output logic [7:0]          slip_count
);

  localparam int ONT_W  = $clog2(LOCK_EDGES + 1);
  localparam int IDLE_W = $clog2(MAX_IDLE_BITS + 2);

  localparam logic [CNT_BITS-1:0] DIV_MIN  = CNT_BITS'(4);
  localparam logic [CNT_BITS-1:0] DIV_RST  = CNT_BITS'(8);
  localparam logic [CNT_BITS-1:0] PH_ONE   = CNT_BITS'(1);
  localparam logic [ONT_W-1:0]    ONT_MAX  = ONT_W'(LOCK_EDGES);
  localparam logic [IDLE_W-1:0]   IDLE_MAX = IDLE_W'(MAX_IDLE_BITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HUNT  = 2'd1,
    S_TRACK = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] phase_q, phase_d;
  logic [CNT_BITS-1:0] div_q, div_d;
  logic [ONT_W-1:0]    ontime_q, ontime_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                locked_q, locked_d;
  logic                sample_q, sample_d;
  logic                timeout_q, timeout_d;

  logic [CNT_BITS-1:0] mid;
  logic [CNT_BITS-1:0] last;
  logic                edge_ontime;

  assign mid         = div_q >> 1;
  assign last        = div_q - PH_ONE;
  // An edge within one sysclk of the bit boundary counts as on time.
  assign edge_ontime = (phase_q == last) || (phase_q == '0) || (phase_q == PH_ONE);

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      div_q     <= DIV_RST;
      ontime_q  <= '0;
      idle_q    <= '0;
      locked_q  <= 1'b0;
      sample_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      div_q     <= div_d;
      ontime_q  <= ontime_d;
      idle_q    <= idle_d;
      locked_q  <= locked_d;
      sample_q  <= sample_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    div_d     = div_q;
    ontime_d  = ontime_q;
    idle_d    = idle_q;
    locked_d  = locked_q;
    sample_d  = 1'b0;
    timeout_d = 1'b0;

    if (!enable) begin
      state_d  = S_IDLE;
      phase_d  = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          div_d   = (div_val < DIV_MIN) ? DIV_MIN : div_val;
          phase_d = '0;
          state_d = S_HUNT;
        end
        S_HUNT: begin
          phase_d = '0;
          if (line_edge) begin
            phase_d  = PH_ONE;
            idle_d   = '0;
            ontime_d = '0;
            state_d  = S_TRACK;
          end
        end
        S_TRACK: begin
          if (line_edge) begin
            // Hard resync; an edge landing on the mid-bit phase eats that strobe.
            phase_d = PH_ONE;
            idle_d  = '0;
            if (edge_ontime) begin
              if (ontime_q != ONT_MAX) begin
                ontime_d = ontime_q + 1'b1;
              end
              if (ontime_d == ONT_MAX) begin
                locked_d = 1'b1;
              end
            end else begin
              ontime_d = '0;
              locked_d = 1'b0;
            end
          end else begin
            phase_d = (phase_q == last) ? '0 : phase_q + PH_ONE;
            if (phase_q == mid) begin
              sample_d = 1'b1;
              idle_d   = idle_q + 1'b1;
              if (idle_q >= IDLE_MAX) begin
                timeout_d = 1'b1;
                locked_d  = 1'b0;
                phase_d   = '0;
                state_d   = S_HUNT;
              end
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          phase_d = '0;
        end
      endcase
    end
  end

`ifdef TIMING_STATS_EN
  logic [7:0] slip_q;
  logic       slip_inc;
  logic       slip_clr;

  assign slip_inc = enable && (state_q == S_TRACK) && line_edge && !edge_ontime;
  assign slip_clr = enable && (state_q == S_IDLE);

  always_ff @(posedge sysclk) begin
    if (rst || slip_clr) begin
      slip_q <= 8'h00;
    end else if (slip_inc && (slip_q != 8'hFF)) begin
      slip_q <= slip_q + 8'h01;
    end
  end

  assign slip_count = slip_q;
`else
  assign slip_count = 8'h00;
`endif

  assign sample_en = sample_q;
  assign timeout   = timeout_q;
  assign phase_cnt = phase_q;
  assign locked    = locked_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_bit_timing_ctrl.sv
// tb/tb_usb_bit_timing_ctrl.sv - scoreboard bench for usb_bit_timing_ctrl against a behavioural timing model.
module tb_usb_bit_timing_ctrl;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] div_val = 4'd8;
  logic       line_edge = 1'b0;
  logic       sample_en;
  logic [3:0] phase_cnt;
  logic       locked;
  logic       busy;
  logic       timeout;
  logic [7:0] slip_count;

  usb_bit_timing_ctrl dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .enable     (enable),
    .div_val    (div_val),
    .line_edge  (line_edge),
    .sample_en  (sample_en),
    .phase_cnt  (phase_cnt),
    .locked     (locked),
    .busy       (busy),
    .timeout    (timeout),
    .slip_count (slip_count)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int c;
    bit s;
    bit t;
  } ev_t;

  ev_t sbq[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int n_dut_strobe = 0;
  int n_dut_to = 0;

  localparam int M_IDLE  = 0;
  localparam int M_HUNT  = 1;
  localparam int M_TRACK = 2;

  int m_mode = M_IDLE;
  int m_ph = 0;
  int m_div = 8;
  int m_ont = 0;
  int m_idle = 0;
  int m_lk = 0;
  int m_slips = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int exp_slip();
`ifdef TIMING_STATS_EN
    return m_slips;
`else
    return 0;
`endif
  endfunction

  // Behavioural reference: one bit period is m_div sysclks, sample point at m_div/2.
  task automatic model_step(input bit r, input bit en, input bit le, input int dv);
    bit ev_s = 0;
    bit ev_t = 0;
    if (r) begin
      m_mode = M_IDLE; m_ph = 0; m_lk = 0; m_div = 8; m_ont = 0; m_idle = 0; m_slips = 0;
    end else if (!en) begin
      m_mode = M_IDLE; m_ph = 0; m_lk = 0;
    end else if (m_mode == M_IDLE) begin
      m_div = (dv < 4) ? 4 : dv;
      m_slips = 0;
      m_mode = M_HUNT;
      m_ph = 0;
    end else if (m_mode == M_HUNT) begin
      if (le) begin
        m_ph = 1; m_idle = 0; m_ont = 0; m_mode = M_TRACK;
      end
    end else if (le) begin
      if (m_ph == m_div - 1 || m_ph == 0 || m_ph == 1) begin
        m_ont = (m_ont + 1 > 3) ? 3 : m_ont + 1;
        if (m_ont == 3) m_lk = 1;
      end else begin
        m_ont = 0;
        m_lk = 0;
        if (m_slips < 255) m_slips++;
      end
      m_ph = 1;
      m_idle = 0;
    end else begin
      if (m_ph == m_div / 2) begin
        ev_s = 1;
        m_idle++;
        if (m_idle > 7) begin
          ev_t = 1; m_lk = 0; m_mode = M_HUNT;
        end
      end
      m_ph = (m_mode == M_HUNT) ? 0 : (m_ph + 1) % m_div;
    end
    if (ev_s || ev_t) sbq.push_back('{c: cyc + 1, s: ev_s, t: ev_t});
  endtask

  task automatic tick(input bit r, input bit en, input bit le, input int dv);
    rst = r;
    enable = en;
    line_edge = le;
    div_val = 4'(dv);
    @(posedge sysclk);
    model_step(r, en, le, dv);
    cyc++;
    mon_en = 1'b1;
    #1;
  endtask

  task automatic settle();
    @(negedge sysclk);
    #1;
  endtask

  initial begin
    ev_t e;
    forever begin
      @(negedge sysclk);
      if (mon_en) begin
        chk("phase_cnt", int'(phase_cnt), m_ph);
        chk("locked", int'(locked), m_lk);
        chk("busy", int'(busy), (m_mode != M_IDLE) ? 1 : 0);
        chk("slip_count", int'(slip_count), exp_slip());
        if (sample_en || timeout) begin
          n_dut_strobe += int'(sample_en);
          n_dut_to += int'(timeout);
          if (sbq.size() == 0 || sbq[0].c != cyc) begin
            chk("unexpected_strobe", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("sample_en", int'(sample_en), int'(e.s));
            chk("timeout", int'(timeout), int'(e.t));
          end
        end else if (sbq.size() != 0 && sbq[0].c == cyc) begin
          e = sbq.pop_front();
          chk("missing_strobe", 0, 1);
        end
      end
    end
  end

  initial begin
    int s0;
    int t0;
    int seg;
    int cd;
    bit en_r;
    bit le;
    bit r;

    tick(1, 0, 0, 8);
    tick(1, 0, 0, 8);
    settle();
    chk("reset_busy", int'(busy), 0);
    chk("reset_phase", int'(phase_cnt), 0);
    chk("reset_sample", int'(sample_en), 0);
    chk("reset_timeout", int'(timeout), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_slip", int'(slip_count), 0);

    tick(0, 1, 0, 8);
    settle();
    chk("enable_busy", int'(busy), 1);

    for (int k = 0; k < 5; k++) begin
      tick(0, 1, 1, 8);
      repeat (7) tick(0, 1, 0, 8);
    end
    settle();
    chk("locked_after_edges", int'(locked), 1);

    for (int k = 0; k < 20 && m_ph != 4; k++) tick(0, 1, 0, 8);
    tick(0, 1, 1, 8);
    settle();
    chk("slip_sample_suppressed", int'(sample_en), 0);
    chk("slip_unlock", int'(locked), 0);
    chk("slip_phase", int'(phase_cnt), 1);
`ifdef TIMING_STATS_EN
    chk("slip_count_one", int'(slip_count), 1);
`else
    chk("slip_count_zero", int'(slip_count), 0);
`endif

    s0 = n_dut_strobe;
    t0 = n_dut_to;
    repeat (80) tick(0, 1, 0, 8);
    settle();
    chk("idle_strobes", n_dut_strobe - s0, 8);
    chk("idle_timeouts", n_dut_to - t0, 1);
    chk("timeout_busy", int'(busy), 1);

    tick(0, 0, 0, 2);
    tick(0, 1, 0, 2);
    tick(0, 1, 1, 2);
    settle();
    s0 = n_dut_strobe;
    repeat (12) tick(0, 1, 0, 2);
    settle();
    chk("div_min_strobes", n_dut_strobe - s0, 3);

    tick(0, 0, 0, 2);
    settle();
    chk("disable_busy", int'(busy), 0);
    chk("disable_locked", int'(locked), 0);

    tick(0, 1, 0, 8);
    tick(0, 1, 1, 8);
    repeat (3) tick(0, 1, 0, 8);
    t0 = n_dut_to;
    tick(1, 1, 0, 8);
    settle();
    chk("rst_mid_busy", int'(busy), 0);
    repeat (20) tick(0, 1, 0, 8);
    settle();
    chk("rst_mid_no_timeout", n_dut_to - t0, 0);

    seg = 0;
    cd = 0;
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) seg = $urandom_range(0, 2);
      r = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 149) == 0) en_r = !en_r;
      else if (!en_r && $urandom_range(0, 3) == 0) en_r = 1'b1;
      case (seg)
        0: le = ($urandom_range(0, 5) == 0);
        1: begin
          if (cd <= 0) begin
            le = 1'b1;
            cd = m_div - 2 + $urandom_range(0, 2);
          end else begin
            le = 1'b0;
            cd--;
          end
        end
        default: le = 1'b0;
      endcase
      tick(r, en_r, le, $urandom_range(0, 15));
    end

    repeat (4) tick(0, 0, 0, 8);
    settle();
    chk("scoreboard_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
